// File: rtl/spm_pkg.sv
// Shared types and helpers for the spm serial-parallel multiplier family.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } spm_state_e;

  // Width of the RUN-cycle counter for a given operand width.
  function automatic int spm_cnt_w(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// One bit of the carry-save chain: registered sum and carry, synchronous clear.
// NEG selects the negating variant (complemented partial product plus a
// carry-in of 1 on the first RUN cycle) used for the sign bit of x when
// SPM_SIGNED_EN is defined.
module spm_csa_cell #(
  parameter bit NEG = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic first,
  input  logic pp,
  input  logic sum_in,
  output logic sum_q,
  output logic sum_d
);

  logic carry_q;
  logic carry_d;
  logic pp_eff;
  logic cin_eff;

  // Full add of partial product, upstream sum and own carry; the negating
  // cell complements its partial product and injects the +1 once.
  always_comb begin
    pp_eff  = NEG ? ~pp : pp;
    cin_eff = carry_q | (NEG & first);
    {carry_d, sum_d} = {1'b0, pp_eff} + {1'b0, sum_in} + {1'b0, cin_eff};
  end

  // Sum and carry flops advance only while the multiplier is running.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (en) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/spm_stream_mult.sv
// Serial-parallel multiplier with valid/ready operand and result handshakes.
// Emits the product LSB first on p_bit and collects it into p.
// Optional two's-complement mode: define SPM_SIGNED_EN.
module spm_stream_mult
  import spm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 p_bit,
  output logic                 p_bit_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int CNT_W = spm_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);

  spm_state_e       state;
  spm_state_e       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_in;
  logic             accept;
  logic             first_cyc;
  logic             fill;
  logic             unused_taps;

  assign accept    = in_valid && in_ready;
  assign first_cyc = p_bit_valid && (cnt == '0);
  assign sum_in    = {1'b0, sum_q[WIDTH-1:1]};
  assign p_bit     = p_bit_valid & sum_d[0];
  assign unused_taps = ^{sum_q[0], sum_d[WIDTH-1:1]};

`ifdef SPM_SIGNED_EN
  assign fill = ys[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    p_bit_valid = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        p_bit_valid = 1'b1;
        busy        = 1'b1;
        if (cnt == CNT_LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, serial operand shift, product collection and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      xr  <= '0;
      ys  <= '0;
      p   <= '0;
      cnt <= '0;
    end else if (accept) begin
      xr  <= x;
      ys  <= y;
      p   <= '0;
      cnt <= '0;
    end else if (p_bit_valid) begin
      ys <= {fill, ys[WIDTH-1:1]};
      p  <= {p_bit, p[2*WIDTH-1:1]};
      if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
`ifdef SPM_SIGNED_EN
    localparam bit IS_NEG = (i == WIDTH - 1);
`else
    localparam bit IS_NEG = 1'b0;
`endif
    spm_csa_cell #(.NEG(IS_NEG)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (p_bit_valid),
      .first  (first_cyc),
      .pp     (xr[i] & ys[0]),
      .sum_in (sum_in[i]),
      .sum_q  (sum_q[i]),
      .sum_d  (sum_d[i])
    );
  end

endmodule

// File: tb/tb_spm_stream_mult.sv
// Directed self-checking bench for spm_stream_mult at WIDTH=8.
// Signed vectors are exercised when SPM_SIGNED_EN is defined.
module tb_spm_stream_mult;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic              p_bit;
  logic              p_bit_valid;
  logic              out_valid;
  logic              out_ready;
  logic [PW-1:0]     p;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  spm_stream_mult #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .p_bit       (p_bit),
    .p_bit_valid (p_bit_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p),
    .busy        (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter for spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the run gets stuck somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one operand pair, follow the serial stream and stop in DONE.
  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] xv,
                               input logic [WIDTH-1:0] yv, input logic [PW-1:0] exp_p);
    logic [PW-1:0] stream;
    int nvalid;
    int early;
    int waitc;
    @(negedge clk);
    x = xv;
    y = yv;
    in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput({tag, "_accept"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    stream = '0;
    nvalid = 0;
    early  = 0;
    for (int k = 0; k < PW; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      stream[k] = p_bit;
      if (p_bit_valid) nvalid++;
      if (out_valid) early++;
    end
    checkOutput({tag, "_stream"}, 64'(stream), 64'(exp_p));
    checkOutput({tag, "_nvalid"}, 64'(nvalid), 64'(PW));
    checkOutput({tag, "_early_ov"}, 64'(early), 64'(0));
    @(negedge clk);
    checkOutput({tag, "_done"}, 64'({out_valid, p_bit_valid, in_ready, busy}), 64'(4'b1001));
    checkOutput({tag, "_p"}, 64'(p), 64'(exp_p));
  endtask

  // Complete the result handshake and confirm the return to IDLE.
  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_release"}, 64'({in_ready, out_valid, busy}), 64'(3'b100));
    out_ready = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, 64'({in_ready, out_valid, p_bit, p_bit_valid, busy, p}),
                64'({5'b10000, 16'h0000}));
  endtask

  initial begin
    logic          stable;
    int            acc_n;
    int            res_n;
    int            acc_cyc [3];
    logic [PW-1:0] res [3];
    logic [WIDTH-1:0] bx [3];
    logic [WIDTH-1:0] by [3];

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;

    // out_ready while nothing is pending must not disturb IDLE
    out_ready = 1'b1;
    @(negedge clk);
    checkResetOutputs("idle_out_ready");
    out_ready = 1'b0;

    applyStimulus("m3x5", 8'd3, 8'd5, 16'h000F);
    releaseResult("m3x5");
    applyStimulus("m0x200", 8'd0, 8'd200, 16'h0000);
    releaseResult("m0x200");
`ifdef SPM_SIGNED_EN
    applyStimulus("sneg1", 8'hFF, 8'hFF, 16'h0001);
    releaseResult("sneg1");
    applyStimulus("smin_max", 8'h80, 8'h7F, 16'hC080);
    releaseResult("smin_max");
    applyStimulus("smin_min", 8'h80, 8'h80, 16'h4000);
    releaseResult("smin_min");
`else
    applyStimulus("m255x255", 8'd255, 8'd255, 16'hFE01);
    releaseResult("m255x255");
`endif

    // Backpressure: hold the result for 10 cycles while a new pair is offered
    applyStimulus("bp", 8'd12, 8'd11, 16'h0084);
    x = 8'd99;
    y = 8'd77;
    in_valid = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (p !== 16'h0084 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    checkOutput("bp_hold", 64'(stable), 64'(1));
    in_valid = 1'b0;
    releaseResult("bp");

    // Reset in the middle of RUN, then a fresh product
    @(negedge clk);
    x = 8'd50;
    y = 8'd60;
    in_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
    end
    checkOutput("mid_run_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("mid_run_reset");
    rst = 1'b0;
    applyStimulus("m7x9", 8'd7, 8'd9, 16'd63);
    releaseResult("m7x9");

    // Back-to-back: in_valid held high with out_ready high
    bx[0] = 8'd2;   by[0] = 8'd3;
    bx[1] = 8'd10;  by[1] = 8'd12;
    bx[2] = 8'd100; by[2] = 8'd2;
    acc_n = 0;
    res_n = 0;
    @(negedge clk);
    x = bx[0];
    y = by[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 150 && res_n < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid) begin
        res[res_n] = p;
        res_n++;
      end
      if (in_ready && in_valid && acc_n < 3) begin
        acc_cyc[acc_n] = cyc;
        acc_n++;
        @(posedge clk);
        #1;
        if (acc_n < 3) begin
          x = bx[acc_n];
          y = by[acc_n];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("b2b_accepts", 64'(acc_n), 64'(3));
    checkOutput("b2b_results", 64'(res_n), 64'(3));
    if (acc_n == 3) begin
      checkOutput("b2b_gap0", 64'(acc_cyc[1] - acc_cyc[0]), 64'(PW + 2));
      checkOutput("b2b_gap1", 64'(acc_cyc[2] - acc_cyc[1]), 64'(PW + 2));
    end
    if (res_n == 3) begin
      checkOutput("b2b_res0", 64'(res[0]), 64'(16'd6));
      checkOutput("b2b_res1", 64'(res[1]), 64'(16'd120));
      checkOutput("b2b_res2", 64'(res[2]), 64'(16'd200));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spm_stream_mult.md
# spm_stream_mult

Parametrised serial-parallel multiplier core for the spm partition family: a chain of carry-save adder cells (one per bit of the parallel operand) fed one bit of the serial operand per cycle. Successor to the fixed-width spm datapath: generic width, a valid/ready operand and result handshake, parallel product capture alongside the serial bit stream, and optional two's-complement mode. It sits between an operand source and a result consumer, and stays partition-friendly: every CSA cell output is a registered, nameable point for equivalence checking.

## Interface
- WIDTH, 32, operand width in bits; legal range 2..64.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  core can accept an operand pair.
- x  in  WIDTH  parallel multiplicand; captured on accept.
- y  in  WIDTH  serial multiplier; captured on accept, consumed LSB first.
- p_bit  out  1  current serial product bit, LSB first.
- p_bit_valid  out  1  p_bit is meaningful this cycle.
- out_valid  out  1  full product available on p.
- out_ready  in  1  consumer takes the product.
- p  out  2*WIDTH  parallel product.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on in_valid && in_ready.
  - RUN -> DONE when cnt == 2*WIDTH-1.
  - DONE -> IDLE on out_valid && out_ready.
- IDLE: in_ready=1. On accept: latch x into xr and y into the shift register ys; clear all CSA sum and carry flops; clear cnt and p.
- RUN, each cycle:
  - Serial input bit = ys[0]. ys shifts right; the fill bit is 0 in unsigned mode.
  - Cell i computes x[i]&ybit plus the sum from cell i+1 plus its own carry. Cell WIDTH-1 receives a 0 sum input.
  - Cell 0's sum is p_bit. It is shifted into p from the MSB end, with p shifting right.
  - cnt increments.
- After 2*WIDTH RUN cycles, p holds the product modulo 2^(2*WIDTH).
- DONE: out_valid=1. p holds stable until the handshake completes. in_ready=0.
- No overlap: a new operand pair cannot be accepted before the DONE handshake. Earliest next accept is the cycle after the handshake.
- cnt width is $clog2(2*WIDTH). cnt does not wrap, because the FSM exits RUN at the terminal count.

## Timing
- Reset (any state, including mid-RUN) values: state=IDLE, in_ready=1, out_valid=0, p_bit=0, p_bit_valid=0, p=0, busy=0, cnt=0, all CSA flops 0. Any in-flight operation is discarded; no partial result is emitted.
- Accept on edge t. p_bit_valid is high for exactly 2*WIDTH cycles, starting after edge t.
- out_valid rises after edge t+2*WIDTH. Minimum throughput is one product per 2*WIDTH+2 cycles.
- in_valid during RUN or DONE is ignored; the offering party holds it.
- out_ready while out_valid=0 has no effect.

## Configuration
- SPM_SIGNED_EN defined:
  - x and y are two's complement.
  - ys fill bit is y[WIDTH-1] (sign extension over the upper WIDTH cycles).
  - Cell WIDTH-1 is a negating cell, so the x[WIDTH-1] partial product carries weight -2^(WIDTH-1). It is implemented as complement plus a carry-in of 1 on the first RUN cycle.
  - p is the signed 2*WIDTH-bit product.
- SPM_SIGNED_EN undefined: unsigned operands, zero fill, all cells identical.

## Structure
- Package spm_pkg:
  - state enum spm_state_e {IDLE, RUN, DONE}.
  - function spm_cnt_w(width) returning $clog2(2*width).
- Sub-module spm_csa_cell: one bit, registered sum and carry, synchronous clear.
  - Parameter NEG selects the negating variant used for bit WIDTH-1 under SPM_SIGNED_EN.
  - Instantiated by a generate loop so each instance is an individually partitionable cell.
- Top holds the FSM, counter, ys and p shift registers, and the handshake.

## Test plan
- WIDTH=8, unsigned: x=3, y=5 -> p=15 (0x000F); p_bit stream 1,1,1,1,0,... over 16 cycles; out_valid 16 cycles after accept.
- WIDTH=8, unsigned: x=255, y=255 -> p=0xFE01. Also x=0, y=200 -> p=0.
- WIDTH=8, SPM_SIGNED_EN:
  - x=-1, y=-1 -> p=0x0001.
  - x=-128, y=127 -> p=0xC080.
  - x=-128, y=-128 -> p=0x4000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> p and out_valid stable, in_ready=0. Release -> IDLE and in_ready=1 next cycle.
- Reset mid-RUN at cnt=5 -> next cycle all outputs at reset values. A fresh 7*9 then yields p=63.
- Back-to-back: in_valid held high with out_ready=1 -> accepts spaced exactly 2*WIDTH+2 cycles, results in order.
